// File: rtl/alu_op_sequencer.sv
// rtl/alu_op_sequencer.sv - issues one ALU operation at a time, holds its operands for the opcode latency, captures ZHI/ZLO
module alu_op_sequencer #(
  parameter int SIMPLE_CYCLES = 1,
  parameter int MUL_CYCLES    = 32,
  parameter int DIV_CYCLES    = 32,
  parameter int CNT_W         = 6
) (
  input  logic        clock,
  input  logic        clear,
  input  logic        start,
  input  logic [4:0]  opcode,
  input  logic [31:0] ra_in,
  input  logic [31:0] rb_in,
  input  logic        abort,
  output logic [4:0]  alu_opcode,
  output logic [31:0] alu_ra,
  output logic [31:0] alu_rb,
  input  logic [31:0] alu_zhi,
  input  logic [31:0] alu_zlo,
  output logic [31:0] z_hi,
  output logic [31:0] z_lo,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic        err_div0
);

  localparam logic [4:0] OP_NOP = 5'b00000;
  localparam logic [4:0] OP_MUL = 5'b01110;
  localparam logic [4:0] OP_DIV = 5'b01111;

  typedef enum logic {IDLE, EXEC} state_t;

  state_t           state;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] lat_m1;
  logic             legal;
  logic             div_zero;

  always_comb begin
    legal  = 1'b1;
    lat_m1 = CNT_W'(SIMPLE_CYCLES - 1);
    case (opcode)
      5'b00011, 5'b00100, 5'b00101, 5'b00110, 5'b00111,
      5'b01000, 5'b01001, 5'b01010, 5'b10000, 5'b10001:
        lat_m1 = CNT_W'(SIMPLE_CYCLES - 1);
      OP_MUL:  lat_m1 = CNT_W'(MUL_CYCLES - 1);
      OP_DIV:  lat_m1 = CNT_W'(DIV_CYCLES - 1);
      default: legal  = 1'b0;
    endcase
  end

  assign div_zero = (opcode == OP_DIV) && (rb_in == 32'd0);

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state      <= IDLE;
      count      <= '0;
      alu_opcode <= OP_NOP;
      alu_ra     <= '0;
      alu_rb     <= '0;
      z_hi       <= '0;
      z_lo       <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      err_div0   <= 1'b0;
    end else begin
      done     <= 1'b0;
      err      <= 1'b0;
      err_div0 <= 1'b0;
      case (state)
        IDLE: begin
          // abort suppresses a coincident start so a cancel never turns into a new request
          if (start && !abort) begin
            if (!legal) begin
              err <= 1'b1;
            end else if (div_zero) begin
              err      <= 1'b1;
              err_div0 <= 1'b1;
            end else begin
              alu_opcode <= opcode;
              alu_ra     <= ra_in;
              alu_rb     <= rb_in;
              count      <= lat_m1;
              busy       <= 1'b1;
              state      <= EXEC;
            end
          end
        end
        EXEC: begin
          if (abort) begin
            alu_opcode <= OP_NOP;
            busy       <= 1'b0;
            state      <= IDLE;
          end else if (count == '0) begin
            z_hi       <= alu_zhi;
            z_lo       <= alu_zlo;
            done       <= 1'b1;
            alu_opcode <= OP_NOP;
            busy       <= 1'b0;
            state      <= IDLE;
          end else begin
            count <= count - CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb/tb_alu_op_sequencer.sv - scoreboard bench for alu_op_sequencer with a latency-aware ALU model
module tb_alu_op_sequencer;
  localparam int SIMPLE = 1;
  localparam int MULC   = 32;
  localparam int DIVC   = 32;

  localparam logic [4:0] OP_ADD = 5'b00011;
  localparam logic [4:0] OP_SUB = 5'b00100;
  localparam logic [4:0] OP_AND = 5'b01001;
  localparam logic [4:0] OP_MUL = 5'b01110;
  localparam logic [4:0] OP_DIV = 5'b01111;

  logic        clock = 1'b0;
  logic        clear = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [4:0]  opcode = '0;
  logic [31:0] ra_in = '0;
  logic [31:0] rb_in = '0;
  logic [4:0]  alu_opcode;
  logic [31:0] alu_ra, alu_rb, alu_zhi, alu_zlo, z_hi, z_lo;
  logic        busy, done, err, err_div0;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int age      = 0;

  typedef struct {
    logic        is_err;
    logic        div0;
    logic [31:0] zhi;
    logic [31:0] zlo;
    int          when;
  } exp_t;
  exp_t sb[$];

  alu_op_sequencer #(
    .SIMPLE_CYCLES(SIMPLE), .MUL_CYCLES(MULC), .DIV_CYCLES(DIVC), .CNT_W(6)
  ) dut (
    .clock(clock), .clear(clear), .start(start), .opcode(opcode),
    .ra_in(ra_in), .rb_in(rb_in), .abort(abort),
    .alu_opcode(alu_opcode), .alu_ra(alu_ra), .alu_rb(alu_rb),
    .alu_zhi(alu_zhi), .alu_zlo(alu_zlo), .z_hi(z_hi), .z_lo(z_lo),
    .busy(busy), .done(done), .err(err), .err_div0(err_div0)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;
  // age = full cycles the current non-NOP opcode has been on the ALU inputs
  always @(posedge clock) age <= (alu_opcode == 5'd0) ? 0 : age + 1;

  // ALU model: result is garbage until operands have been held for the opcode latency
  always_comb begin
    logic signed [63:0] prod;
    int lat;
    prod    = $signed({{32{alu_ra[31]}}, alu_ra}) * $signed({{32{alu_rb[31]}}, alu_rb});
    lat     = SIMPLE;
    alu_zhi = 32'd0;
    alu_zlo = 32'd0;
    case (alu_opcode)
      OP_ADD: alu_zlo = alu_ra + alu_rb;
      OP_SUB: alu_zlo = alu_ra - alu_rb;
      OP_AND: alu_zlo = alu_ra & alu_rb;
      OP_MUL: begin lat = MULC; alu_zhi = prod[63:32]; alu_zlo = prod[31:0]; end
      OP_DIV: begin
        lat = DIVC;
        if (alu_rb != 0) begin alu_zhi = alu_ra / alu_rb; alu_zlo = alu_ra % alu_rb; end
      end
      default: ;
    endcase
    if (age < lat - 1) begin
      alu_zhi = 32'hDEAD_BEEF;
      alu_zlo = 32'hDEAD_BEEF;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  always @(negedge clock) begin
    if (clear && (done || err)) begin
      if (sb.size() == 0) begin
        check("unexpected_event", {61'd0, done, err, err_div0}, 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("event_kind", {61'd0, done, err, err_div0},
              e.is_err ? {61'd0, 1'b0, 1'b1, e.div0} : 64'd4);
        check("event_cycle", 64'(cyc), 64'(e.when));
        if (!e.is_err) begin
          check("z_hi", {32'd0, z_hi}, {32'd0, e.zhi});
          check("z_lo", {32'd0, z_lo}, {32'd0, e.zlo});
        end
      end
    end
  end

  // Called at a negedge; drives one start for one cycle and optionally books the expected event.
  task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                       input bit push, input bit is_err, input bit d0,
                       input logic [31:0] ehi, input logic [31:0] elo, input int lat);
    opcode = op;
    ra_in  = a;
    rb_in  = b;
    start  = 1'b1;
    if (push) sb.push_back('{is_err, d0, ehi, elo, cyc + 1 + (is_err ? 0 : lat)});
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic wait_drain(input int max_cycles);
    for (int i = 0; i < max_cycles && sb.size() != 0; i++) @(negedge clock);
    check("sb_drained", 64'(sb.size()), 64'd0);
  endtask

  task automatic check_all_zero(input string name);
    check(name, {alu_ra, alu_rb}, 64'd0);
    check({name, "_z"}, {z_hi, z_lo}, 64'd0);
    check({name, "_ctl"}, {55'd0, alu_opcode, busy, done, err, err_div0}, 64'd0);
  endtask

  initial begin
    int e0;
    @(negedge clock);
    check_all_zero("reset");
    clear = 1'b1;
    @(negedge clock);

    // add 5+7, single-cycle latency
    issue(OP_ADD, 32'd5, 32'd7, 1, 0, 0, 32'd0, 32'd12, SIMPLE);
    check("add_busy", {58'd0, busy, alu_opcode}, {58'd0, 1'b1, OP_ADD});
    @(negedge clock);
    check("add_after", {58'd0, busy, alu_opcode}, 64'd0);
    wait_drain(4);
    check("and_zlo_prev", {32'd0, z_lo}, 64'd12);

    issue(OP_AND, 32'h0000_F0F0, 32'h0000_FF00, 1, 0, 0, 32'd0, 32'h0000_F000, SIMPLE);
    wait_drain(4);

    // multiply -1*3 with operand inputs toggled during EXEC
    issue(OP_MUL, 32'hFFFF_FFFF, 32'd3, 1, 0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFD, MULC);
    for (int i = 0; i < MULC - 1; i++) begin
      ra_in  = $urandom;
      rb_in  = $urandom;
      opcode = OP_ADD;
      if (i % 8 == 0) begin
        check("mul_hold", {alu_ra, alu_rb}, {32'hFFFF_FFFF, 32'd3});
        check("mul_busy", {58'd0, busy, alu_opcode}, {58'd0, 1'b1, OP_MUL});
      end
      @(negedge clock);
    end
    wait_drain(4);

    // rejects
    issue(OP_DIV, 32'd9, 32'd0, 1, 1, 1, 32'd0, 32'd0, 0);
    check("div0_busy", {63'd0, busy}, 64'd0);
    issue(5'b11111, 32'd1, 32'd1, 1, 1, 0, 32'd0, 32'd0, 0);
    check("illegal_busy", {63'd0, busy}, 64'd0);
    wait_drain(4);
    check("reject_z", {z_hi, z_lo}, {32'hFFFF_FFFF, 32'hFFFF_FFFD});

    // div 100/7, ignored start during EXEC, back-to-back sub in the done cycle
    e0 = cyc + 1;
    issue(OP_DIV, 32'd100, 32'd7, 1, 0, 0, 32'd14, 32'd2, DIVC);
    repeat (3) @(negedge clock);
    issue(OP_ADD, 32'd1, 32'd1, 0, 0, 0, 32'd0, 32'd0, 0);
    check("div_hold", {27'd0, alu_opcode, alu_rb}, {27'd0, OP_DIV, 32'd7});
    while (cyc < e0 + DIVC) @(negedge clock);
    issue(OP_SUB, 32'd9, 32'd4, 1, 0, 0, 32'd0, 32'd5, SIMPLE);
    wait_drain(6);

    // abort at cycle 10 of a multiply
    issue(OP_MUL, 32'd2, 32'd3, 0, 0, 0, 32'd0, 32'd0, 0);
    repeat (9) @(negedge clock);
    abort = 1'b1;
    @(negedge clock);
    abort = 1'b0;
    check("abort_idle", {58'd0, busy, alu_opcode}, 64'd0);
    repeat (MULC + 4) @(negedge clock);
    check("abort_z", {z_hi, z_lo}, {32'd0, 32'd5});

    // abort coincident with the final cycle
    issue(OP_MUL, 32'd2, 32'd3, 0, 0, 0, 32'd0, 32'd0, 0);
    repeat (MULC - 1) @(negedge clock);
    abort = 1'b1;
    @(negedge clock);
    abort = 1'b0;
    check("abort_last", {58'd0, busy, alu_opcode}, 64'd0);
    repeat (4) @(negedge clock);
    check("abort_last_z", {z_hi, z_lo}, {32'd0, 32'd5});

    // abort in IDLE blocks a coincident start
    abort = 1'b1;
    issue(OP_ADD, 32'd3, 32'd3, 0, 0, 0, 32'd0, 32'd0, 0);
    abort = 1'b0;
    check("abort_idle_start", {63'd0, busy}, 64'd0);

    // asynchronous reset mid-divide, between clock edges
    issue(OP_DIV, 32'd50, 32'd5, 0, 0, 0, 32'd0, 32'd0, 0);
    repeat (5) @(negedge clock);
    #2 clear = 1'b0;
    #1 check_all_zero("async_reset");
    @(negedge clock);
    clear = 1'b1;
    @(negedge clock);
    issue(OP_ADD, 32'd1, 32'd1, 1, 0, 0, 32'd0, 32'd2, SIMPLE);
    wait_drain(4);
    repeat (3) @(negedge clock);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
